// File: rtl/dlsc_demosaic_vng6_outbuf.sv
// Output FIFO after the VNG6 output stage: buffers RGB pixels, adds row/frame-end tags,
// and throttles the demosaic core so its in-flight pixels always have room.
module dlsc_demosaic_vng6_outbuf #(
  parameter int DATA   = 8,
  parameter int DEPTH  = 16,
  parameter int SLACK  = 4,
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA-1:0]   in_red,
  input  logic [DATA-1:0]   in_green,
  input  logic [DATA-1:0]   in_blue,
  input  logic              in_valid,
  output logic              core_clk_en,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [3*DATA-1:0] out_data,
  output logic              out_row_last,
  output logic              out_frame_last,
  output logic              overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 3*DATA + 2;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(HEIGHT + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   SLACK_C  = (AW+1)'(SLACK);

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_clk_en;
  logic          r_overflow;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_row_last;
  logic          w_frame_last;
  logic [AW:0]   w_count_next;
  logic [AW:0]   w_free;
  logic [EW-1:0] w_head;

  assign w_full       = (r_count == DEPTH_C);
  assign w_empty      = (r_count == '0);
  // A pixel arriving while full is dropped even if a pop frees a slot this cycle.
  assign w_push       = in_valid && !w_full;
  assign w_pop        = !w_empty && out_ready;
  assign w_row_last   = (r_col == COL_LAST);
  assign w_frame_last = w_row_last && (r_row == ROW_LAST);
  assign w_count_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign w_free       = DEPTH_C - w_count_next;

  // Stage p0: capture pixel with its tags (storage is not reset)
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_frame_last, w_row_last, in_blue, in_green, in_red};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_clk_en   <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_row_last) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count  <= w_count_next;
      r_clk_en <= (w_free > SLACK_C);
      if (in_valid && w_full) r_overflow <= 1'b1;
    end
  end

  // Stage p1: head entry presented combinationally, zeroed while empty
  assign w_head         = w_empty ? '0 : r_mem[r_rd_ptr];
  assign out_valid      = !w_empty;
  assign out_data       = w_head[3*DATA-1:0];
  assign out_row_last   = w_head[3*DATA];
  assign out_frame_last = w_head[3*DATA+1];
  assign core_clk_en    = r_clk_en;
  assign overflow       = r_overflow;

endmodule

// File: tb/tb_dlsc_demosaic_vng6_outbuf.sv
// Scoreboard bench for dlsc_demosaic_vng6_outbuf: a pixel-index reference model queues
// expected tagged pixels; a negedge monitor compares each popped pixel and the status outputs.
module tb_dlsc_demosaic_vng6_outbuf;

  localparam int DATA = 8, DEPTH = 16, SLACK = 4, WIDTH = 4, HEIGHT = 2;

  logic clk = 0;
  logic rst = 1;
  logic [DATA-1:0] in_red = '0, in_green = '0, in_blue = '0;
  logic in_valid = 0;
  logic out_ready = 0;
  logic core_clk_en, out_valid, out_row_last, out_frame_last, overflow;
  logic [3*DATA-1:0] out_data;

  dlsc_demosaic_vng6_outbuf #(
    .DATA(DATA), .DEPTH(DEPTH), .SLACK(SLACK), .WIDTH(WIDTH), .HEIGHT(HEIGHT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_red(in_red), .in_green(in_green), .in_blue(in_blue), .in_valid(in_valid),
    .core_clk_en(core_clk_en), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_row_last(out_row_last), .out_frame_last(out_frame_last),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy, accepted-pixel index, flags
  logic [25:0] sb[$];
  int  m_cnt  = 0;
  int  m_idx  = 0;
  bit  m_en   = 1;
  bit  m_ovf  = 0;
  bit  m_live = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_idx = 0; m_en = 1; m_ovf = 0; m_live = 1;
      sb.delete();
    end else if (m_live) begin
      int pop, push, pos;
      bit rl, fl;
      pop  = (m_cnt != 0 && out_ready) ? 1 : 0;
      push = 0;
      if (in_valid) begin
        if (m_cnt == DEPTH) m_ovf = 1;
        else begin
          push = 1;
          pos  = m_idx % (WIDTH * HEIGHT);
          rl   = (pos % WIDTH) == WIDTH - 1;
          fl   = pos == WIDTH * HEIGHT - 1;
          sb.push_back({fl, rl, in_blue, in_green, in_red});
          m_idx++;
        end
      end
      m_cnt = m_cnt + push - pop;
      m_en  = (DEPTH - m_cnt) > SLACK;
    end
  end

  // Monitor
  bit          st_prev = 0;
  logic [25:0] st_val;

  always @(negedge clk) begin
    if (m_live) begin
      logic [25:0] cur, exp;
      cur = {out_frame_last, out_row_last, out_data};
      chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      chk("core_clk_en", 32'(core_clk_en), 32'(m_en));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (st_prev) chk("stall_hold", 32'(cur), 32'(st_val));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("pop_unexpected", 32'(1), 32'(0));
        else begin
          exp = sb.pop_front();
          chk("pixel", 32'(cur), 32'(exp));
        end
      end
      st_prev = out_valid && !out_ready && !rst;
      st_val  = cur;
    end
  end

  task automatic step(input bit v, input logic [23:0] px, input bit rdy);
    @(posedge clk); #1;
    in_valid  = v;
    {in_blue, in_green, in_red} = px;
    out_ready = rdy;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 24'(0), rdy);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_en", 32'(core_clk_en), 1);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_data", 32'({out_frame_last, out_row_last, out_data}), 0);

    // 1: tagging over one frame plus the first pixel of the next
    for (int i = 1; i <= 9; i++) begin
      step(1, 24'(i), 1);
      step(0, 24'(0), 1);
    end
    idle(4, 1);

    // 2: fill to 12 then 16 with no drain
    for (int i = 0; i < 16; i++) step(1, 24'($urandom), 0);
    step(0, 24'(0), 0);
    @(negedge clk);
    chk("full_no_ovf", 32'(overflow), 0);

    // 3: pixel arriving at full with a simultaneous pop is dropped
    step(1, 24'h0000AA, 1);
    step(0, 24'(0), 0);
    @(negedge clk);
    chk("ovf_set", 32'(overflow), 1);
    step(1, 24'h0000BB, 0);
    idle(20, 1);

    // 4: steady push/pop at occupancy 5
    for (int i = 0; i < 5; i++) step(1, 24'($urandom), 0);
    for (int i = 0; i < 20; i++) step(1, 24'($urandom), 1);
    step(0, 24'(0), 0);
    idle(8, 1);

    // 5: stalled head holds, one pop reopens the core enable
    step(1, 24'h030201, 0);
    for (int i = 0; i < 11; i++) step(1, 24'($urandom), 0);
    idle(5, 0);
    step(0, 24'(0), 1);
    idle(4, 0);
    idle(16, 1);

    // 6: reset with 7 buffered pixels
    for (int i = 0; i < 7; i++) step(1, 24'($urandom), 0);
    step(0, 24'(0), 0);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_en", 32'(core_clk_en), 1);
    chk("mid_rst_ovf", 32'(overflow), 0);
    for (int i = 0; i < 5; i++) step(1, 24'($urandom), 1);
    idle(4, 1);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        @(posedge clk); #1 rst = 1; in_valid = 0;
        @(posedge clk); #1 rst = 0;
      end else begin
        step($urandom_range(0, 2) != 0, 24'($urandom), $urandom_range(0, 3) != 0);
      end
    end
    idle(DEPTH + 4, 1);
    @(negedge clk);
    chk("final_empty", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
